// File: rtl/lane_judge_pkg.sv
// Shared types and band geometry for the per-lane note judge.
package lane_judge_pkg;

  typedef enum logic [1:0] {J_NONE, J_PERFECT, J_NEAR, J_MISS} judge_t;
  typedef enum logic {READY, LOCKOUT} lock_state_t;

  localparam int HIT_ROW_LO  = 0;
  localparam int HIT_ROW_HI  = 1;
  localparam int NEAR_ROW_LO = 2;
  localparam int NEAR_ROW_HI = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lane_judge_key_edge_detect.sv
// Rising-edge detector for the already-synchronised lane button.
module key_edge_detect (
  input  logic clk,
  input  logic RST,
  input  logic level,
  output logic rise
);

  logic key_d_q;
  logic key_d_d;

  assign key_d_d = level;
  assign rise    = level & ~key_d_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) key_d_q <= 1'b0;
    else      key_d_q <= key_d_d;
  end

endmodule

// File: rtl/lane_judge.sv
// One-lane judge: grades presses against the bottom bands, tracks misses on each field shift,
// and keeps a saturating combo and points total.
module lane_judge
  import lane_judge_pkg::*;
#(
  parameter int LANE_LO     = 4,
  parameter int LANE_HI     = 7,
  parameter int LOCK_CYCLES = 1024,
  parameter int PERFECT_PTS = 2,
  parameter int NEAR_PTS    = 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               KEY,
  input  logic               shift,
  input  logic [15:0][15:0]  RedPixels,
  output logic               score,
  output logic               near,
  output logic               miss,
  output logic [7:0]         combo,
  output logic [15:0]        points
);

  localparam int CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [15:0] LaneMask = (16'hFFFF << LANE_LO) & (16'hFFFF >> (15 - LANE_HI));

  logic press;
  logic hit_occ, near_occ;
  logic ready;
  judge_t grade;
  logic jh_p, jn_p, miss_now;

  lock_state_t state_q, state_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic jh_q, jh_d, jn_q, jn_d;
  logic score_q, score_d, near_q, near_d, miss_q, miss_d;
  logic [7:0]  combo_q, combo_d;
  logic [15:0] points_q, points_d;
  logic [16:0] pts_sum;
  logic [15:0] pts_add;

  key_edge_detect u_key_edge (
    .clk   (clk),
    .RST   (RST),
    .level (KEY),
    .rise  (press)
  );

  assign hit_occ  = |((RedPixels[HIT_ROW_LO] | RedPixels[HIT_ROW_HI]) & LaneMask);
  assign near_occ = |((RedPixels[NEAR_ROW_LO] | RedPixels[NEAR_ROW_HI]) & LaneMask);

  // Lockout FSM: state register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= READY;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lockout FSM: next state. A press in READY that grades nothing arms the lockout.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      READY: begin
        if (press && grade == J_NONE) begin
          state_d    = LOCKOUT;
          lock_cnt_d = '0;
        end
      end
      LOCKOUT: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (lock_cnt_q == CntW'(LOCK_CYCLES - 1)) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  // Lockout FSM: outputs
  always_comb begin
    ready = (state_q == READY);
  end

  // Grading; the hit band outranks the near band.
  always_comb begin
    grade = J_NONE;
    if (hit_occ && !jh_q)       grade = J_PERFECT;
    else if (near_occ && !jn_q) grade = J_NEAR;
  end

  always_comb begin
    score_d = ready & press & (grade == J_PERFECT);
    near_d  = ready & press & (grade == J_NEAR);
    jh_p    = jh_q | score_d;
    jn_p    = jn_q | near_d;
    // Shift sees flags already updated by a same-cycle press.
    miss_now = shift & hit_occ & ~jh_p;
    miss_d   = miss_now;
    jh_d     = shift ? jn_p : jh_p;
    jn_d     = shift ? 1'b0 : jn_p;

    pts_add  = score_d ? 16'(PERFECT_PTS) : (near_d ? 16'(NEAR_PTS) : 16'd0);
    pts_sum  = {1'b0, points_q} + {1'b0, pts_add};
    points_d = pts_sum[16] ? 16'hFFFF : pts_sum[15:0];

    combo_d = combo_q;
    if (miss_now)               combo_d = 8'd0;
    else if (score_d || near_d) combo_d = sat_inc8(combo_q);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      jh_q     <= 1'b0;
      jn_q     <= 1'b0;
      score_q  <= 1'b0;
      near_q   <= 1'b0;
      miss_q   <= 1'b0;
      combo_q  <= 8'd0;
      points_q <= 16'd0;
    end else begin
      jh_q     <= jh_d;
      jn_q     <= jn_d;
      score_q  <= score_d;
      near_q   <= near_d;
      miss_q   <= miss_d;
      combo_q  <= combo_d;
      points_q <= points_d;
    end
  end

  assign score  = score_q;
  assign near   = near_q;
  assign miss   = miss_q;
  assign combo  = combo_q;
  assign points = points_q;

endmodule

// File: tb/tb_lane_judge.sv
// Directed self-checking bench for lane_judge (default parameters: lane cols 4-7, lockout 1024).
module tb_lane_judge;

  logic              clk;
  logic              RST;
  logic              KEY;
  logic              shift;
  logic [15:0][15:0] RedPixels;
  logic              score, near, miss;
  logic [7:0]        combo;
  logic [15:0]       points;

  int checks   = 0;
  int failures = 0;
  int grades;

  lane_judge dut (
    .clk       (clk),
    .RST       (RST),
    .KEY       (KEY),
    .shift     (shift),
    .RedPixels (RedPixels),
    .score     (score),
    .near      (near),
    .miss      (miss),
    .combo     (combo),
    .points    (points)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic n, input logic m,
                         input logic [7:0] c, input logic [15:0] p);
    chk({tag, ".score"},  {31'd0, score}, {31'd0, s});
    chk({tag, ".near"},   {31'd0, near},  {31'd0, n});
    chk({tag, ".miss"},   {31'd0, miss},  {31'd0, m});
    chk({tag, ".combo"},  {24'd0, combo}, {24'd0, c});
    chk({tag, ".points"}, {16'd0, points}, {16'd0, p});
  endtask

  initial begin
    RST = 1'b0; KEY = 1'b0; shift = 1'b0; RedPixels = '0;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 8'd0, 16'd0);
    RST = 1'b1;
    tick();

    // Perfect: note in hit band
    RedPixels[1][5] = 1'b1;
    KEY = 1'b1; tick();
    chk_out("perfect", 1, 0, 0, 8'd1, 16'd2);
    KEY = 1'b0; tick();
    chk("perfect_pulse_end", {31'd0, score}, 32'd0);
    RedPixels = '0; shift = 1'b1; tick();
    chk_out("empty_shift", 0, 0, 0, 8'd1, 16'd2);
    shift = 1'b0;

    // Near, then the judged note shifts into the hit band and must not miss
    RedPixels[2][4] = 1'b1;
    KEY = 1'b1; tick();
    chk_out("near", 0, 1, 0, 8'd2, 16'd3);
    KEY = 1'b0; shift = 1'b1; tick();
    chk("near_shift1.miss", {31'd0, miss}, 32'd0);
    RedPixels = '0; RedPixels[0][4] = 1'b1; tick();
    chk_out("near_inherit", 0, 0, 0, 8'd2, 16'd3);
    shift = 1'b0; RedPixels = '0;

    // Build combo to 5 with press+shift perfects, then miss
    RedPixels[1][7] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      KEY = 1'b1; shift = 1'b1; tick();
      chk("combo_build.score", {31'd0, score}, 32'd1);
      KEY = 1'b0; shift = 1'b0; tick();
    end
    chk_out("combo5", 0, 0, 0, 8'd5, 16'd9);
    RedPixels = '0; RedPixels[0][6] = 1'b1; shift = 1'b1; tick();
    chk_out("miss", 0, 0, 1, 8'd0, 16'd9);
    shift = 1'b0; RedPixels = '0; tick();

    // Empty press -> lockout; press 10 cycles later ignored; press after lockout grades
    KEY = 1'b1; tick();
    chk_out("empty_press", 0, 0, 0, 8'd0, 16'd9);
    KEY = 1'b0;
    repeat (9) tick();
    RedPixels[0][5] = 1'b1;
    KEY = 1'b1; tick();
    chk_out("locked_press", 0, 0, 0, 8'd0, 16'd9);
    KEY = 1'b0;
    repeat (1024 + 2 - 11) tick();
    KEY = 1'b1; tick();
    chk_out("after_lockout", 1, 0, 0, 8'd1, 16'd11);
    KEY = 1'b0; RedPixels = '0; shift = 1'b1; tick();
    shift = 1'b0;

    // Press and shift together with note in hit band
    RedPixels[0][4] = 1'b1;
    KEY = 1'b1; shift = 1'b1; tick();
    chk_out("press_shift", 1, 0, 0, 8'd2, 16'd13);
    shift = 1'b0; KEY = 1'b0; tick();

    // Held KEY grades once
    KEY = 1'b1;
    grades = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      grades += int'(score) + int'(near) + int'(miss);
    end
    chk("hold_grades", grades, 32'd1);
    chk_out("hold_end", 0, 0, 0, 8'd3, 16'd15);
    KEY = 1'b0; tick();

    // Async reset mid-play clears immediately
    RedPixels = '0; RedPixels[1][6] = 1'b1; KEY = 1'b1;
    RST = 1'b0; #1;
    chk_out("rst_async", 0, 0, 0, 8'd0, 16'd0);
    tick();
    chk_out("rst_held", 0, 0, 0, 8'd0, 16'd0);
    KEY = 1'b0; RST = 1'b1; tick();

    // Saturation: 32767 perfects reach 16'hFFFE, then clamp at 16'hFFFF
    for (int i = 0; i < 32767; i++) begin
      KEY = 1'b1; shift = 1'b1; tick();
      KEY = 1'b0; shift = 1'b0; tick();
    end
    chk_out("pts_fffe", 0, 0, 0, 8'hFF, 16'hFFFE);
    KEY = 1'b1; shift = 1'b1; tick();
    chk_out("pts_ffff", 1, 0, 0, 8'hFF, 16'hFFFF);
    KEY = 1'b0; shift = 1'b0; tick();
    KEY = 1'b1; shift = 1'b1; tick();
    chk_out("pts_sat", 1, 0, 0, 8'hFF, 16'hFFFF);
    KEY = 1'b0; shift = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
